// File: rtl/axi_mm_read_arbiter.sv
// Two-client read arbiter in front of an AXI memory-mapped read adapter; one transaction at a time.
// Build option: define AXI_RD_ARB_FIXED_PRIO_EN for fixed client-0 priority instead of round-robin.
module axi_mm_read_arbiter #(
  parameter int AXI_AWIDTH = 32,
  parameter int AXI_DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,

  input  logic                  c0_read_request_valid,
  output logic                  c0_read_request_ready,
  input  logic [AXI_AWIDTH-1:0] c0_read_addr,
  input  logic [31:0]           c0_read_len,
  input  logic [2:0]            c0_read_size,
  input  logic [1:0]            c0_read_burst,
  output logic [AXI_DWIDTH-1:0] c0_read_data,
  output logic                  c0_read_data_valid,
  input  logic                  c0_read_data_ready,

  input  logic                  c1_read_request_valid,
  output logic                  c1_read_request_ready,
  input  logic [AXI_AWIDTH-1:0] c1_read_addr,
  input  logic [31:0]           c1_read_len,
  input  logic [2:0]            c1_read_size,
  input  logic [1:0]            c1_read_burst,
  output logic [AXI_DWIDTH-1:0] c1_read_data,
  output logic                  c1_read_data_valid,
  input  logic                  c1_read_data_ready,

  output logic                  core_read_request_valid,
  input  logic                  core_read_request_ready,
  output logic [AXI_AWIDTH-1:0] core_read_addr,
  output logic [31:0]           core_read_len,
  output logic [2:0]            core_read_size,
  output logic [1:0]            core_read_burst,
  input  logic [AXI_DWIDTH-1:0] core_read_data,
  input  logic                  core_read_data_valid,
  output logic                  core_read_data_ready,

  output logic [1:0]            grant,
  output logic                  busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [1:0] state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       busy_q, busy_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tgt_q, tgt_d;

  logic       req_any_s;
  logic       win_c1_s;
  logic       sel_c1_s;
  logic       sel_req_valid_s;
  logic       sel_data_ready_s;
  logic [31:0] sel_len_s;
  logic       req_hs_s;
  logic       beat_s;

  assign req_any_s = c0_read_request_valid | c1_read_request_valid;
  assign sel_c1_s  = grant_q[1];

`ifdef AXI_RD_ARB_FIXED_PRIO_EN
  // Winner selection: client 1 only wins when client 0 is not asking.
  always_comb begin
    win_c1_s = c1_read_request_valid & ~c0_read_request_valid;
  end
`else
  logic last_c1_q, last_c1_d;

  // Winner selection: on a tie the client not granted last time wins.
  always_comb begin
    win_c1_s = c1_read_request_valid & (~c0_read_request_valid | ~last_c1_q);
  end

  // Last-granted pointer advances at each arbitration decision.
  always_comb begin
    last_c1_d = last_c1_q;
    if ((state_q == ST_IDLE) && req_any_s) begin
      last_c1_d = win_c1_s;
    end else begin
      last_c1_d = last_c1_q;
    end
  end

  // Pointer register; resets to client 1 so client 0 takes the first tie.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_c1_q <= 1'b1;
    end else begin
      last_c1_q <= last_c1_d;
    end
  end
`endif

  // Request-side mux toward the adapter, driven from the current owner.
  always_comb begin
    sel_req_valid_s  = 1'b0;
    sel_data_ready_s = 1'b0;
    sel_len_s        = 32'd0;
    core_read_addr   = '0;
    core_read_size   = 3'd0;
    core_read_burst  = 2'd0;
    if (sel_c1_s) begin
      sel_req_valid_s  = c1_read_request_valid;
      sel_data_ready_s = c1_read_data_ready;
      sel_len_s        = c1_read_len;
      core_read_addr   = c1_read_addr;
      core_read_size   = c1_read_size;
      core_read_burst  = c1_read_burst;
    end else begin
      sel_req_valid_s  = c0_read_request_valid;
      sel_data_ready_s = c0_read_data_ready;
      sel_len_s        = c0_read_len;
      core_read_addr   = c0_read_addr;
      core_read_size   = c0_read_size;
      core_read_burst  = c0_read_burst;
    end
  end

  assign core_read_len = sel_len_s;

  // Handshake qualifiers and routed ready/valid, all gated by state and owner.
  always_comb begin
    core_read_request_valid = (state_q == ST_REQ) & sel_req_valid_s;
    core_read_data_ready    = (state_q == ST_DATA) & sel_data_ready_s;
    c0_read_request_ready   = (state_q == ST_REQ) & grant_q[0] & core_read_request_ready;
    c1_read_request_ready   = (state_q == ST_REQ) & grant_q[1] & core_read_request_ready;
    c0_read_data_valid      = (state_q == ST_DATA) & grant_q[0] & core_read_data_valid;
    c1_read_data_valid      = (state_q == ST_DATA) & grant_q[1] & core_read_data_valid;
    req_hs_s                = core_read_request_valid & core_read_request_ready;
    beat_s                  = core_read_data_valid & core_read_data_ready;
  end

  // Response data is broadcast; the non-owner's copy is don't-care since its valid stays low.
  assign c0_read_data = core_read_data;
  assign c1_read_data = core_read_data;

  // Transaction sequencing: arbitrate, forward one request, count beats back.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_any_s) begin
          grant_d = win_c1_s ? 2'b10 : 2'b01;
          state_d = ST_REQ;
        end else begin
          grant_d = 2'b00;
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        // A withdrawn request simply leaves us here; the owner is never re-picked.
        if (req_hs_s) begin
          tgt_d   = sel_len_s[7:0];
          cnt_d   = 8'd0;
          state_d = ST_DATA;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_DATA: begin
        if (beat_s) begin
          if (cnt_q == tgt_q) begin
            state_d = ST_IDLE;
            grant_d = 2'b00;
            cnt_d   = 8'd0;
          end else begin
            cnt_d   = cnt_q + 8'd1;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
        cnt_d   = 8'd0;
        tgt_d   = 8'd0;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Control registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
      cnt_q   <= 8'd0;
      tgt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = busy_q;

endmodule

// File: doc/axi_mm_read_arbiter.md
AXI_MM_READ_ARBITER -- requirements
Module: axi_mm_read_arbiter

Interface
REQ-001 The block SHALL have parameters: AXI_AWIDTH, default 32, address width; AXI_DWIDTH, default 32, data width.
REQ-002 The block SHALL have port clk, input, 1, sole clock; all logic is rising-edge.
REQ-003 The block SHALL have port resetn, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have ports cN_read_request_valid/ready (in/out, 1) for N=0,1: client read request handshake.
REQ-005 The block SHALL have ports cN_read_addr (in, AXI_AWIDTH), cN_read_len (in, 32), cN_read_size (in, 3) and cN_read_burst (in, 2) for N=0,1: client request fields.
REQ-006 The block SHALL have ports cN_read_data (out, AXI_DWIDTH) and cN_read_data_valid/ready (out/in, 1) for N=0,1: client response beats.
REQ-007 The block SHALL have ports core_read_request_valid/ready (out/in, 1) and core_read_addr/len/size/burst (out; AXI_AWIDTH/32/3/2): request side toward the AXI memory-mapped adapter.
REQ-008 The block SHALL have ports core_read_data (in, AXI_DWIDTH) and core_read_data_valid/ready (in/out, 1): response beats from the adapter.
REQ-009 The block SHALL have port grant, output, 2, one-hot owner (bit N = client N; 00 = none).
REQ-010 The block SHALL have port busy, output, 1, high whenever state != IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, REQ and DATA, and SHALL serialize transactions: one outstanding request, no overlap.
REQ-012 In IDLE, when any client request_valid is high, the block SHALL select a winner, register the one-hot grant and go to REQ next cycle; arbitration latency is 1 cycle.
REQ-013 Arbitration SHALL be round-robin: with both valid, the client not granted last wins; with one valid, that client wins.
REQ-014 In REQ, the core_read_* request outputs SHALL combinationally mirror the granted client, and only the granted client's request_ready SHALL equal core_read_request_ready.
REQ-015 On core request handshake, the block SHALL capture len[7:0] as beat target (beats = len[7:0]+1), clear the beat counter and go to DATA; len[31:8] SHALL be forwarded but ignored for counting.
REQ-016 In DATA, core_read_data/valid SHALL route to the granted client, and core_read_data_ready SHALL equal that client's data_ready.
REQ-017 The block SHALL count beats only on valid&&ready; on the handshake where count == target it SHALL go to IDLE next cycle with grant = 00.
REQ-018 Client backpressure (data_ready low) SHALL stall DATA indefinitely without beat loss or counter change.
REQ-019 The non-granted client SHALL see request_ready=0 and data_valid=0 at all times; its cN_read_data SHALL be don't-care.
REQ-020 A request withdrawn in REQ (valid dropped by the granted client) is illegal; the block SHALL hold REQ and SHALL NOT re-arbitrate.
REQ-021 A single-beat transfer (len=0) SHALL complete on its first data handshake.
REQ-022 Back-to-back: the minimum gap from the last data beat to the next core_read_request_valid SHALL be 2 cycles (DATA->IDLE->REQ).

Reset
REQ-023 resetn low SHALL asynchronously force state IDLE, grant=00, busy=0, beat counter=0, and last-granted pointer=client 1 (so client 0 wins the first tie).
REQ-024 All ready/valid outputs SHALL be 0 during reset; reset mid-DATA SHALL abandon the transaction, and the adapter SHALL be reset on the same resetn.
REQ-025 Reset deassertion SHALL be synchronized externally; the block SHALL leave IDLE no earlier than the first rising edge after deassertion.

Configuration
REQ-026 With macro AXI_RD_ARB_FIXED_PRIO_EN defined, client 0 SHALL always win when both are valid, and the last-granted pointer SHALL be absent.
REQ-027 Without AXI_RD_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-013.

Verification
REQ-028 Scenario: reset, then c0 only, addr=0x1000, len=3, always ready -> core request addr=0x1000 len=3; 4 beats delivered to c0; grant 01 then 00; busy low 1 cycle after 4th beat.
REQ-029 Scenario: c0 and c1 both valid from reset, len=0 each, held -> grant order c0, c1, c0, c1 (round-robin); with AXI_RD_ARB_FIXED_PRIO_EN: c0 every time.
REQ-030 Scenario: c1 len=7, c1 data_ready toggling 1/0 every cycle -> exactly 8 beats to c1 in order, data values match adapter order, c0 sees data_valid=0 throughout.
REQ-031 Scenario: core_read_request_ready held low 10 cycles in REQ -> state stays REQ, addr/len stable, no counter activity.
REQ-032 Scenario: resetn asserted after beat 2 of len=5 on c0 -> same-instant grant=00, busy=0, all valids/readies 0; a subsequent c1 len=1 request completes with 2 beats.
